// File: rtl/ccff_chain_loader_if.sv
// Host-side bitstream word channel for the configuration-chain loader.
// The host (JTAG/SPI bridge) is the master; the loader is the slave.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes bitstream words from a host, serializes
// exactly CHAIN_LEN bits MSB-first onto ccff_head, and raises ccff_shift_en
// only on cycles where a valid bit is being driven.
// Optional build macro CCFF_CHAIN_LOADER_READBACK_EN adds a CRC-8 (poly 0x07)
// over the bits that ccff_tail pushes out during a load.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                start,
  input  logic                abort,
  ccff_chain_loader_if.slave  host,
  output logic                ccff_head,
  output logic                ccff_shift_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done,
  output logic [7:0]          readback_crc
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned NB_W  = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] sreg, sreg_n;
  logic [CNT_W-1:0]  remaining, remaining_n;
  logic [NB_W-1:0]   nbits, nbits_n;
  logic              ready_n, head_n, shift_en_n, busy_n, done_n;
  logic              start_ok;

  assign start_ok = (state == IDLE) && start && !abort;

  // State, datapath and registered outputs.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state           <= IDLE;
      sreg            <= '0;
      remaining       <= '0;
      nbits           <= '0;
      host.word_ready <= 1'b0;
      ccff_head       <= 1'b0;
      ccff_shift_en   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_n;
      sreg            <= sreg_n;
      remaining       <= remaining_n;
      nbits           <= nbits_n;
      host.word_ready <= ready_n;
      ccff_head       <= head_n;
      ccff_shift_en   <= shift_en_n;
      busy            <= busy_n;
      done            <= done_n;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register
  // in step with the state they describe.
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    remaining_n = remaining;
    nbits_n     = nbits;

    unique case (state)
      IDLE: begin
        if (start_ok) begin
          remaining_n = CNT_W'(CHAIN_LEN);
          state_n     = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          remaining_n = '0;
          nbits_n     = '0;
          state_n     = IDLE;
        end else if (host.word_valid && host.word_ready) begin
          sreg_n  = host.word_data;
          nbits_n = (32'(remaining) >= WORD_W) ? NB_W'(WORD_W) : NB_W'(remaining);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          remaining_n = '0;
          nbits_n     = '0;
          state_n     = IDLE;
        end else begin
          sreg_n      = sreg << 1;
          remaining_n = remaining - CNT_W'(1);
          nbits_n     = nbits - NB_W'(1);
          if (nbits == NB_W'(1)) begin
            state_n = (remaining == CNT_W'(1)) ? DONE : FETCH;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    ready_n    = (state_n == FETCH);
    shift_en_n = (state_n == SHIFT);
    head_n     = (state_n == SHIFT) && sreg_n[WORD_W-1];
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == DONE);
  end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [7:0] crc_n;

  // CRC-8 over tail bits; cleared on an accepted start, advanced on each shift.
  always_comb begin
    crc_n = readback_crc;
    if (start_ok) begin
      crc_n = 8'h00;
    end else if (ccff_shift_en) begin
      crc_n = {readback_crc[6:0], 1'b0} ^
              (((readback_crc[7] ^ ccff_tail) != 1'b0) ? 8'h07 : 8'h00);
    end
  end

  // Readback CRC register.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      readback_crc <= 8'h00;
    end else begin
      readback_crc <= crc_n;
    end
  end
`else
  // The tail is only observed when readback is built in.
  logic unused_tail;
  assign unused_tail  = ccff_tail;
  assign readback_crc = 8'h00;
`endif

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain transmitter: drives the ccff_head input of a chain of configuration-memory cells (ccff_head -> ... -> ccff_tail) clocked by prog_clk.
- Accepts bitstream words from a host over a valid/ready interface and serializes them onto the chain, exactly CHAIN_LEN bits per load.
- Produces a shift-enable that the clock-gating cell uses, so the chain only advances on bits the loader actually drives.
- Sits between the bitstream host (JTAG/SPI bridge) and the head of a tile's configuration chain.

Parameters:
- CHAIN_LEN, 20, number of configuration cells in the target chain (>= 1).
- WORD_W, 8, bitstream word width from host (>= 1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the remaining-bit counter (derived; not overridden).

Ports:
- prog_clk  input  1  configuration clock.
- prog_reset  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  synchronous cancel of an in-progress load.
- word_data  input  WORD_W  bitstream word; MSB shifted first.
- word_valid  input  1  host word valid.
- word_ready  output  1  loader accepts word this cycle.
- ccff_head  output  1  serial data into the chain.
- ccff_shift_en  output  1  chain shifts on the prog_clk edge where this is 1.
- ccff_tail  input  1  serial data out of the chain's last cell.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when all CHAIN_LEN bits are shifted.
- readback_crc  output  8  CRC of bits observed on ccff_tail (see Optional Feature).

Behaviour:
- Reset values: state IDLE; word_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, readback_crc=8'h00; remaining=0; shift register cleared.
- Reset is asynchronous. Asserting it mid-load returns to IDLE immediately. No done is issued and the chain is left partially written.
- All outputs are registered.
- States:
  - IDLE: start=1 loads remaining=CHAIN_LEN and moves to FETCH on the next edge.
  - FETCH: word_ready=1. On word_valid & word_ready:
    - capture word_data into the shift register;
    - nbits = min(WORD_W, remaining);
    - go to SHIFT.
    - word_valid low: stay in FETCH with ccff_shift_en=0, so the chain holds.
  - SHIFT: each cycle drive ccff_head = current MSB with ccff_shift_en=1, then shift left and decrement remaining and nbits. When nbits reaches 0:
    - remaining > 0: go to FETCH;
    - remaining = 0: go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Each word costs 1 FETCH cycle (minimum) plus nbits SHIFT cycles. Total ccff_shift_en-high cycles per load is exactly CHAIN_LEN.
- Words needed per load: ceil(CHAIN_LEN/WORD_W). In the final word only the top (CHAIN_LEN mod WORD_W) bits are used (all bits when the remainder is 0); the lower bits are discarded.
- Bit order: the first bit shifted ends in the cell nearest ccff_tail; the last bit shifted ends in the cell at ccff_head.
- start while busy: ignored. start coincident with abort in IDLE: abort wins, stay in IDLE.
- abort in FETCH or SHIFT: next state IDLE, and ccff_shift_en=0 from that edge on. No done pulse; a word accepted in the same cycle is discarded.
- word_valid while not in FETCH: ignored, word_ready=0.
- ccff_head returns to 0 whenever ccff_shift_en=0.

Optional Feature:
- Macro: CCFF_CHAIN_LOADER_READBACK_EN.
- Defined:
  - readback_crc is a CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) updated with ccff_tail on every edge where ccff_shift_en=1.
  - This captures the chain's previous contents as they are pushed out.
  - The CRC is cleared when start is accepted, and is stable and valid from the done cycle until the next accepted start.
- Not defined: readback_crc is constant 8'h00 and no CRC logic is synthesized.

Test Plan:
- CHAIN_LEN=20, WORD_W=8; start, host supplies 8'hA5, 8'h3C, 8'hF0 with valid always high -> exactly 20 shift_en cycles; ccff_head sequence 10100101 00111100 1111; done one cycle after the last shift; 3 handshakes.
- Same load with word_valid low for 5 cycles before word 2 -> shift_en low throughout the stall; same 20-bit sequence; busy stays high.
- abort asserted on the 4th SHIFT cycle of word 2 -> IDLE next cycle; shift_en=0; no done; a following start performs a full fresh 20-bit load.
- prog_reset pulsed mid-SHIFT -> all outputs 0 immediately; start during a load -> ignored, shift count unaffected.
- CHAIN_LEN=16, WORD_W=8 (exact multiple) -> 2 words, 16 shifts, no discarded bits; CHAIN_LEN=3 -> single word, only bits [7:5] shifted.
- READBACK_EN: model the chain as a 20-bit shift register preloaded with 20'hFFFFF -> readback_crc equals the reference CRC-8 of twenty 1-bits. With the macro undefined -> readback_crc stays 8'h00.
